inst_fetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch unit. Sits between the I-cache and the decoder.
- Issues sequential PC requests to the I-cache and buffers returned instructions, with their PCs, in a DEPTH-entry FIFO.
- Presents the FIFO head to the decoder over a valid/ready handshake.
- Stalls when the queue cannot accept another response. Flushes the queue and redirects on jump, and discards any in-flight stale response.

---
 rtl/inst_fetch_queue_pkg.sv | 18 +
 rtl/inst_fetch_queue_fetch_fifo.sv | 69 ++++++
 rtl/inst_fetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and fetch FSM encoding for the instruction fetch queue.
// Imported by the top module and by the FIFO sub-module.
package inst_fetch_queue_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding {instruction, pc} pairs; flush clears all pointers.
// Head data is read straight from storage, so it is valid whenever o_empty is low.
module inst_fetch_queue_fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_head];
    // Flush wins over any same-cycle push or pop.
    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: issues sequential PC requests to the I-cache, queues
// returned words with their PCs, and redirects/flushes on jump.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    output logic                             ic_req_valid,
    output logic [ADDR_WIDTH-1:0]            ic_req_pc,
    input  logic                             ic_resp_valid,
    input  logic [INST_WIDTH-1:0]            ic_resp_inst,
    output logic                             dec_valid,
    output logic [INST_WIDTH-1:0]            dec_inst,
    output logic [ADDR_WIDTH-1:0]            dec_pc,
    input  logic                             dec_ready,
    input  logic                             jump_flag,
    input  logic [ADDR_WIDTH-1:0]            target_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int unsigned ENTRY_W = INST_WIDTH + ADDR_WIDTH;

    fetch_state_e            r_state;
    fetch_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic [ADDR_WIDTH-1:0]   r_req_pc;
    logic [ADDR_WIDTH-1:0]   w_req_pc_nxt;
    logic                    r_req_valid;
    logic                    w_req_valid_nxt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_full;
    logic                    w_empty;
    logic [ENTRY_W-1:0]      w_fifo_wdata;
    logic [ENTRY_W-1:0]      w_fifo_rdata;

    // A jump outranks both enqueue and dequeue; rdy low suppresses everything.
    assign w_flush      = (rdy == HIGH) && jump_flag;
    assign w_push       = (rdy == HIGH) && !jump_flag && (r_state == S_WAIT) && ic_resp_valid;
    assign w_pop        = (rdy == HIGH) && !jump_flag && !w_empty && dec_ready;
    assign w_fifo_wdata = {ic_resp_inst, r_pc};

    inst_fetch_queue_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_fifo_wdata),
        .o_data  (w_fifo_rdata),
        .o_count (queue_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dec_valid    = !w_empty;
    assign dec_inst     = w_fifo_rdata[ENTRY_W-1:ADDR_WIDTH];
    assign dec_pc       = w_fifo_rdata[ADDR_WIDTH-1:0];
    assign ic_req_valid = r_req_valid;
    assign ic_req_pc    = r_req_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= ADDR_WIDTH'(RESET_PC);
            r_req_pc    <= '0;
            r_req_valid <= LOW;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_req_valid <= w_req_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_pc_nxt    = r_req_pc;
        w_req_valid_nxt = r_req_valid;
        if (rdy == HIGH) begin
            case (r_state)
                S_IDLE: begin
                    w_req_valid_nxt = FALSE;
                    if (jump_flag) begin
                        w_pc_nxt = target_pc;
                    end else if (!w_full) begin
                        w_req_pc_nxt    = r_pc;
                        w_req_valid_nxt = TRUE;
                        w_state_nxt     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (jump_flag) begin
                        // A same-cycle response is simply dropped; otherwise the
                        // stale response still has to be absorbed in DISCARD.
                        w_pc_nxt        = target_pc;
                        w_req_valid_nxt = FALSE;
                        w_state_nxt     = ic_resp_valid ? S_IDLE : S_DISCARD;
                    end else if (ic_resp_valid) begin
                        w_pc_nxt        = r_pc + ADDR_WIDTH'(PC_STEP);
                        w_req_valid_nxt = FALSE;
                        w_state_nxt     = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    w_req_valid_nxt = FALSE;
                    if (jump_flag) begin
                        w_pc_nxt = target_pc;
                    end
                    if (ic_resp_valid) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_req_valid_nxt = FALSE;
                    w_state_nxt     = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (QUEUE_DEPTH = 8).
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ic_req_valid;
    logic [31:0] ic_req_pc;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_inst;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        jump_flag;
    logic [31:0] target_pc;
    logic [3:0]  queue_count;

    int n_pass;
    int n_total;

    inst_fetch_queue #(
        .ADDR_WIDTH  (32),
        .INST_WIDTH  (32),
        .QUEUE_DEPTH (8),
        .RESET_PC    (0),
        .PC_STEP     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ic_req_valid  (ic_req_valid),
        .ic_req_pc     (ic_req_pc),
        .ic_resp_valid (ic_resp_valid),
        .ic_resp_inst  (ic_resp_inst),
        .dec_valid     (dec_valid),
        .dec_inst      (dec_inst),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .jump_flag     (jump_flag),
        .target_pc     (target_pc),
        .queue_count   (queue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        rdy           = 1'b1;
        ic_resp_valid = 1'b0;
        ic_resp_inst  = '0;
        dec_ready     = 1'b0;
        jump_flag     = 1'b0;
        target_pc     = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Advance until a request is visible; an expired budget counts as a failure.
    task automatic wait_req();
        for (int i = 0; i < 10; i++) begin
            if (ic_req_valid === 1'b1) return;
            step();
        end
        n_total++;
        $display("FAIL req_timeout: ic_req_valid=%b required 1 within 10 cycles", ic_req_valid);
    endtask

    task automatic respond(input logic [31:0] inst);
        ic_resp_valid = 1'b1;
        ic_resp_inst  = inst;
        step();
        ic_resp_valid = 1'b0;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wait_req();
            respond(base + 32'(i));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        ic_resp_valid = 1'b0;
        ic_resp_inst = '0;
        dec_ready = 1'b0;
        jump_flag = 1'b0;
        target_pc = '0;
        step();
        n_total++;
        if (ic_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", ic_req_valid);
        else n_pass++;
        n_total++;
        if (ic_req_pc !== 32'h0) $display("FAIL reset_req_pc: got %h want 0", ic_req_pc);
        else n_pass++;
        n_total++;
        if (dec_valid !== 1'b0) $display("FAIL reset_dec_valid: got %b want 0", dec_valid);
        else n_pass++;
        n_total++;
        if (queue_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", queue_count);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(4 * k);
            wait_req();
            n_total++;
            if (ic_req_pc !== exp_pc) $display("FAIL seq_req_pc[%0d]: got %h want %h", k, ic_req_pc, exp_pc);
            else n_pass++;
            respond(32'h0000_0013);
            n_total++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_inst !== 32'h13)
                $display("FAIL seq_dec[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=00000013",
                         k, dec_valid, dec_pc, dec_inst, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill(8, 32'h100);
        n_total++;
        if (queue_count !== 4'd8) $display("FAIL bp_full_count: got %0d want 8", queue_count);
        else n_pass++;
        step();
        step();
        step();
        n_total++;
        if (ic_req_valid !== 1'b0) $display("FAIL bp_no_req: got %b want 0", ic_req_valid);
        else n_pass++;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        n_total++;
        if (queue_count !== 4'd7 || ic_req_valid !== 1'b0 || dec_pc !== 32'h4)
            $display("FAIL bp_one_pop: got count=%0d req=%b pc=%h want count=7 req=0 pc=00000004",
                     queue_count, ic_req_valid, dec_pc);
        else n_pass++;
        wait_req();
        n_total++;
        if (ic_req_pc !== 32'h20) $display("FAIL bp_next_req_pc: got %h want 00000020", ic_req_pc);
        else n_pass++;
        respond(32'h108);
        n_total++;
        if (queue_count !== 4'd8) $display("FAIL bp_refill_count: got %0d want 8", queue_count);
        else n_pass++;
        // Drain across the pointer wrap: heads are pc 0x4..0x20 in order.
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 + 4 * i) || dec_inst !== 32'(32'h101 + i))
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, dec_valid, dec_pc, dec_inst, 32'(4 + 4 * i), 32'(32'h101 + i));
            else n_pass++;
            step();
        end
        dec_ready = 1'b0;
        n_total++;
        if (queue_count !== 4'd0 || dec_valid !== 1'b0)
            $display("FAIL bp_drained: got count=%0d v=%b want count=0 v=0", queue_count, dec_valid);
        else n_pass++;
    endtask

    task automatic test_jump_wait();
        do_reset();
        fill(1, 32'h11);
        wait_req();
        jump_flag = 1'b1;
        target_pc = 32'h1000;
        step();
        jump_flag = 1'b0;
        n_total++;
        if (queue_count !== 4'd0 || dec_valid !== 1'b0 || ic_req_valid !== 1'b0)
            $display("FAIL jw_flush: got count=%0d v=%b req=%b want 0 0 0", queue_count, dec_valid, ic_req_valid);
        else n_pass++;
        step();
        step();
        n_total++;
        if (ic_req_valid !== 1'b0) $display("FAIL jw_discard_no_req: got %b want 0", ic_req_valid);
        else n_pass++;
        respond(32'hDEAD_BEEF);
        n_total++;
        if (queue_count !== 4'd0 || dec_valid !== 1'b0)
            $display("FAIL jw_stale_dropped: got count=%0d v=%b want 0 0", queue_count, dec_valid);
        else n_pass++;
        wait_req();
        n_total++;
        if (ic_req_pc !== 32'h1000) $display("FAIL jw_target_req: got %h want 00001000", ic_req_pc);
        else n_pass++;
        respond(32'hCAFE_0001);
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h1000 || dec_inst !== 32'hCAFE_0001 || queue_count !== 4'd1)
            $display("FAIL jw_first_entry: got v=%b pc=%h inst=%h count=%0d want 1 00001000 cafe0001 1",
                     dec_valid, dec_pc, dec_inst, queue_count);
        else n_pass++;
    endtask

    task automatic test_jump_resp();
        do_reset();
        fill(3, 32'h50);
        wait_req();
        n_total++;
        if (queue_count !== 4'd3 || ic_req_pc !== 32'hC)
            $display("FAIL jr_setup: got count=%0d pc=%h want 3 0000000c", queue_count, ic_req_pc);
        else n_pass++;
        jump_flag     = 1'b1;
        target_pc     = 32'h2000;
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'h0000_0BAD;
        dec_ready     = 1'b1;
        step();
        jump_flag     = 1'b0;
        ic_resp_valid = 1'b0;
        dec_ready     = 1'b0;
        n_total++;
        if (queue_count !== 4'd0 || dec_valid !== 1'b0 || ic_req_valid !== 1'b0)
            $display("FAIL jr_flush: got count=%0d v=%b req=%b want 0 0 0", queue_count, dec_valid, ic_req_valid);
        else n_pass++;
        step();
        n_total++;
        if (ic_req_valid !== 1'b1 || ic_req_pc !== 32'h2000)
            $display("FAIL jr_target_req: got req=%b pc=%h want 1 00002000", ic_req_valid, ic_req_pc);
        else n_pass++;
        respond(32'h77);
        n_total++;
        if (dec_pc !== 32'h2000 || dec_inst !== 32'h77 || queue_count !== 4'd1)
            $display("FAIL jr_first_entry: got pc=%h inst=%h count=%0d want 00002000 00000077 1",
                     dec_pc, dec_inst, queue_count);
        else n_pass++;
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        fill(1, 32'hA0);
        wait_req();
        rdy       = 1'b0;
        dec_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                ic_resp_valid = 1'b1;
                ic_resp_inst  = 32'hBB;
            end
            if (c == 3) begin
                jump_flag = 1'b1;
                target_pc = 32'h3000;
            end
            step();
            ic_resp_valid = 1'b0;
            jump_flag     = 1'b0;
            n_total++;
            if (ic_req_valid !== 1'b1 || ic_req_pc !== 32'h4 || dec_valid !== 1'b1 ||
                dec_pc !== 32'h0 || dec_inst !== 32'hA0 || queue_count !== 4'd1)
                $display("FAIL freeze[%0d]: got req=%b rpc=%h v=%b pc=%h inst=%h cnt=%0d want 1 4 1 0 a0 1",
                         c, ic_req_valid, ic_req_pc, dec_valid, dec_pc, dec_inst, queue_count);
            else n_pass++;
        end
        rdy       = 1'b1;
        dec_ready = 1'b0;
        respond(32'hA4);
        n_total++;
        if (queue_count !== 4'd2 || dec_pc !== 32'h0 || ic_req_valid !== 1'b0)
            $display("FAIL freeze_resume: got cnt=%0d pc=%h req=%b want 2 0 0", queue_count, dec_pc, ic_req_valid);
        else n_pass++;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        n_total++;
        if (dec_pc !== 32'h4 || dec_inst !== 32'hA4 || ic_req_valid !== 1'b1 || ic_req_pc !== 32'h8)
            $display("FAIL freeze_after: got pc=%h inst=%h req=%b rpc=%h want 4 a4 1 8",
                     dec_pc, dec_inst, ic_req_valid, ic_req_pc);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        fill(4, 32'hC0);
        wait_req();
        n_total++;
        if (queue_count !== 4'd4 || ic_req_valid !== 1'b1)
            $display("FAIL ar_setup: got cnt=%0d req=%b want 4 1", queue_count, ic_req_valid);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (dec_valid !== 1'b0 || queue_count !== 4'd0 || ic_req_valid !== 1'b0 || ic_req_pc !== 32'h0)
            $display("FAIL ar_immediate: got v=%b cnt=%0d req=%b rpc=%h want 0 0 0 0",
                     dec_valid, queue_count, ic_req_valid, ic_req_pc);
        else n_pass++;
        step();
        rst = 1'b0;
        wait_req();
        n_total++;
        if (ic_req_pc !== 32'h0) $display("FAIL ar_first_req: got %h want 00000000", ic_req_pc);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_jump_wait();
        test_jump_resp();
        test_rdy_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
